// File: rtl/wb_sequencer_if.sv
// Writeback sequencer bus: ALU and mul/div result inputs, the register-file
// write port, and the stall / hazard-mask outputs.
interface wb_sequencer_if;
    logic        halt_sys;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [3:0]  md_addr;
    logic [31:0] md_data;
    logic        md_r0;
    logic        write_en;
    logic        R0_en;
    logic [3:0]  write_address;
    logic [31:0] write_data;
    logic        wb_stall;
    logic [15:0] pending_mask;

    // Upstream side: produces results, consumes the write port and status.
    modport master (
        output halt_sys, alu_valid, alu_addr, alu_data,
        output md_valid, md_addr, md_data, md_r0,
        input  md_ready, write_en, R0_en, write_address, write_data,
        input  wb_stall, pending_mask
    );

    // Sequencer side.
    modport slave (
        input  halt_sys, alu_valid, alu_addr, alu_data,
        input  md_valid, md_addr, md_data, md_r0,
        output md_ready, write_en, R0_en, write_address, write_data,
        output wb_stall, pending_mask
    );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: merges ALU results (priority) and FIFO-buffered mul/div
// results onto the register-file write port. Optional WB_PENDING_MASK_EN builds pending_mask.
module wb_sequencer #(
    parameter int FIFO_DEPTH = 2,
    parameter int AGE_MAX    = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_sequencer_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    typedef logic [PTR_W:0] ptr_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        r0;
    } entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_FIFO
    } wb_sel_t;

    entry_t             mem [FIFO_DEPTH];
    ptr_t               wr_ptr;
    ptr_t               rd_ptr;
    ptr_t               count;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    entry_t             head;
    logic [AGE_W-1:0]   age;
    wb_sel_t            sel;

    logic               wb_en;
    logic               wb_r0;
    logic [3:0]         wb_addr;
    logic [31:0]        wb_data;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == ptr_t'(FIFO_DEPTH));
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    assign bus.md_ready = !full && !bus.halt_sys && !rst;
    assign push         = bus.md_valid && bus.md_ready;

    // The head is only visible a cycle after its push, so there is no bypass.
    always_comb begin
        sel = SEL_NONE;
        if (!bus.halt_sys) begin
            if (bus.alu_valid)
                sel = SEL_ALU;
            else if (!empty)
                sel = SEL_FIFO;
        end
    end

    assign pop = (sel == SEL_FIFO);

    // NOTE: storage is not reset; entry validity comes solely from the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= '{addr: bus.md_addr, data: bus.md_data, r0: bus.md_r0};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (!bus.halt_sys) begin
            if (pop || empty)
                age <= '0;
            else if (age != AGE_W'(AGE_MAX))
                age <= age + 1'b1;
        end
    end

    assign bus.wb_stall = (age == AGE_W'(AGE_MAX));

    // Idle cycles drop only the enables; address and data keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_r0   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (!bus.halt_sys) begin
            unique case (sel)
                SEL_ALU: begin
                    wb_en   <= 1'b1;
                    wb_r0   <= 1'b0;
                    wb_addr <= bus.alu_addr;
                    wb_data <= {16'h0, bus.alu_data};
                end
                SEL_FIFO: begin
                    wb_en   <= 1'b1;
                    wb_r0   <= head.r0;
                    wb_addr <= head.addr;
                    wb_data <= head.data;
                end
                default: begin
                    wb_en   <= 1'b0;
                    wb_r0   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.write_en      = wb_en;
    assign bus.R0_en         = wb_r0;
    assign bus.write_address = wb_addr;
    assign bus.write_data    = wb_data;

`ifdef WB_PENDING_MASK_EN
    logic [15:0]      mask;
    logic [PTR_W-1:0] idx;

    always_comb begin
        mask = '0;
        idx  = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (ptr_t'(k) < count) begin
                idx  = rd_ptr[PTR_W-1:0] + PTR_W'(k);
                mask = mask | (16'h1 << mem[idx].addr) | {15'h0, mem[idx].r0};
            end
        end
        if (wb_en)
            mask = mask | (16'h1 << wb_addr);
        mask = mask | {15'h0, wb_r0};
    end

    assign bus.pending_mask = mask;
`else
    assign bus.pending_mask = 16'h0;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: vector table for steady-state traffic,
// plus hand-written aging, halt and mid-operation reset sequences.
module tb_wb_sequencer;

    logic clk = 1'b0;
    logic rst;

    wb_sequencer_if bus();

    wb_sequencer #(.FIFO_DEPTH(2), .AGE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        alu_v;
        logic [3:0]  alu_a;
        logic [15:0] alu_d;
        logic        md_v;
        logic [3:0]  md_a;
        logic [31:0] md_d;
        logic        md_r0;
        logic        ready;
        logic        we;
        logic        r0;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [15:0] mask;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Expected pending_mask depends on whether the feature is built.
    function automatic logic [15:0] em(input logic [15:0] m);
`ifdef WB_PENDING_MASK_EN
        return m;
`else
        return 16'h0 & m;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic mr);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.md_valid  = mv;
        bus.md_addr   = ma;
        bus.md_data   = md;
        bus.md_r0     = mr;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic we, input logic r0,
                             input logic [3:0] addr, input logic [31:0] data,
                             input logic stall, input logic [15:0] mask);
        check({tag, " write_en"}, {31'h0, bus.write_en}, {31'h0, we});
        check({tag, " R0_en"}, {31'h0, bus.R0_en}, {31'h0, r0});
        check({tag, " write_address"}, {28'h0, bus.write_address}, {28'h0, addr});
        check({tag, " write_data"}, bus.write_data, data);
        check({tag, " wb_stall"}, {31'h0, bus.wb_stall}, {31'h0, stall});
        check({tag, " pending_mask"}, {16'h0, bus.pending_mask}, {16'h0, em(mask)});
    endtask

    initial begin
        //         alu_v alu_a  alu_d     md_v  md_a   md_d          r0    ready we    r0    addr   data          mask
        tbl[0]  = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_1234, 16'h0020};
        tbl[1]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_1234, 16'h0000};
        tbl[2]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_1234, 16'h0009};
        tbl[3]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 16'h0009};
        tbl[4]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'hDEAD_BEEF, 16'h0000};
        tbl[5]  = '{1'b1, 4'd7, 16'h00FF, 1'b1, 4'd2, 32'h0001_0002, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_00FF, 16'h0084};
        tbl[6]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd4, 32'h0003_0004, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h0000_1111, 16'h0016};
        tbl[7]  = '{1'b1, 4'd6, 16'h6666, 1'b1, 4'd9, 32'h0000_0009, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 32'h0000_6666, 16'h0054};
        tbl[8]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd9, 32'h0000_0009, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h0001_0002, 16'h0014};
        tbl[9]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd9, 32'h0000_0009, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 32'h0003_0004, 16'h0210};
        tbl[10] = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h0000_0009, 16'h0200};
        tbl[11] = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0000_0009, 16'h0000};

        // Reset state
        rst          = 1'b1;
        bus.halt_sys = 1'b0;
        idle();
        #2;
        check_out("reset", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 16'h0);
        check("reset md_ready", {31'h0, bus.md_ready}, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post-reset md_ready", {31'h0, bus.md_ready}, 32'h1);

        // Vector table: ALU writes, mul/div with R0, priority and FIFO full
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].alu_v, tbl[i].alu_a, tbl[i].alu_d,
                  tbl[i].md_v, tbl[i].md_a, tbl[i].md_d, tbl[i].md_r0);
            #1;
            check($sformatf("row%0d md_ready", i), {31'h0, bus.md_ready}, {31'h0, tbl[i].ready});
            step();
            check_out($sformatf("row%0d", i), tbl[i].we, tbl[i].r0, tbl[i].addr,
                      tbl[i].data, 1'b0, tbl[i].mask);
        end

        // Aging: one entry blocked by continuous ALU traffic
        drive(1'b1, 4'd1, 16'h0001, 1'b1, 4'hA, 32'hAAAA_0000, 1'b0);
        step();
        check("age push stall", {31'h0, bus.wb_stall}, 32'h0);
        drive(1'b1, 4'd1, 16'h0001, 1'b0, 4'h0, 32'h0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("age blocked%0d stall", i), {31'h0, bus.wb_stall}, 32'h0);
        end
        step();
        check_out("age4", 1'b1, 1'b0, 4'd1, 32'h0000_0001, 1'b1, 16'h0402);
        step();
        check_out("age sat alu wins", 1'b1, 1'b0, 4'd1, 32'h0000_0001, 1'b1, 16'h0402);
        idle();
        step();
        check_out("age drain", 1'b1, 1'b0, 4'hA, 32'hAAAA_0000, 1'b0, 16'h0400);

        // Halt with an output held and one entry buffered
        drive(1'b1, 4'd2, 16'h2222, 1'b1, 4'hC, 32'hCCCC_0001, 1'b0);
        step();
        check_out("pre-halt", 1'b1, 1'b0, 4'd2, 32'h0000_2222, 1'b0, 16'h1004);
        bus.halt_sys = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'hD, 32'hDDDD_0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("halt%0d md_ready", i), {31'h0, bus.md_ready}, 32'h0);
            step();
            check_out($sformatf("halt%0d", i), 1'b1, 1'b0, 4'd2, 32'h0000_2222, 1'b0, 16'h1004);
        end
        bus.halt_sys = 1'b0;
        idle();
        #1;
        check("release md_ready", {31'h0, bus.md_ready}, 32'h1);
        step();
        check_out("release drain", 1'b1, 1'b0, 4'hC, 32'hCCCC_0001, 1'b0, 16'h1000);
        step();
        check_out("release idle", 1'b0, 1'b0, 4'hC, 32'hCCCC_0001, 1'b0, 16'h0000);

        // Reset mid-operation with two entries buffered
        drive(1'b1, 4'd1, 16'h0011, 1'b1, 4'hE, 32'hEEEE_0000, 1'b0);
        step();
        drive(1'b1, 4'd2, 16'h0022, 1'b1, 4'hF, 32'hFFFF_0000, 1'b0);
        step();
        check_out("pre-reset full", 1'b1, 1'b0, 4'd2, 32'h0000_0022, 1'b0, 16'hC004);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check_out("async reset", 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 16'h0);
        check("async reset md_ready", {31'h0, bus.md_ready}, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("after reset%0d", i), 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 16'h0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

- Writeback sequencer that drives the write port of `mem_register`: `write_en`, `R0_en`, `write_address`, `write_data`.
- Merges two result sources:
  - single-cycle ALU results, which have priority and are never backpressured;
  - multiply/divide results, which arrive over a valid/ready handshake and are buffered in a small FIFO.
- Holds state across `halt_sys`, requests a pipeline stall when buffered results age out, and exports a pending-write mask for hazard detection.

## Interface
Parameters:
- FIFO_DEPTH, 2, mul/div result FIFO entries; power of two, ≥2
- AGE_MAX, 4, cycles a FIFO head may wait before `wb_stall` asserts; ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- halt_sys  in  1  system halt; freezes all state
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  4  ALU destination register
- alu_data  in  16  ALU result
- md_valid  in  1  mul/div result offered
- md_ready  out  1  FIFO accepts this cycle
- md_addr  in  4  mul/div low-word destination
- md_data  in  32  {high, low} result
- md_r0  in  1  also write high word to R0
- write_en  out  1  register-file write enable
- R0_en  out  1  register-file R0 high-word enable
- write_address  out  4  register-file write address
- write_data  out  32  register-file write data
- wb_stall  out  1  request that upstream insert an ALU bubble
- pending_mask  out  16  bit i set = write to Ri buffered or on output

## Operation
- Output stage is registered. Each non-halted cycle loads exactly one of the following, in priority order:
  1. ALU result: `write_en`=1, `R0_en`=0, `write_address`=`alu_addr`, `write_data`={16'h0, `alu_data`}.
  2. FIFO head, when `alu_valid`=0 and the FIFO is non-empty: `write_en`=1, `R0_en`=`md_r0`, address=`md_addr`, data=`md_data`. The head is popped.
  3. Otherwise: `write_en`=0 and `R0_en`=0. Address and data hold their previous values.
- FIFO push occurs when `md_valid && md_ready`.
  - `md_ready` = !full && !`halt_sys` && !`rst`.
  - A full FIFO does not accept a push even if a pop occurs in the same cycle.
  - There is no bypass: a result pushed into an empty FIFO is popped no earlier than the next cycle.
- Age counter, 0..AGE_MAX:
  - clears on pop, on empty FIFO, and on reset;
  - increments each non-halted cycle in which the FIFO is non-empty and the head is not popped;
  - saturates at AGE_MAX.
- `wb_stall` = (age == AGE_MAX).
  - It is a request only: if `alu_valid` still arrives while `wb_stall`=1, the ALU still wins.
- `md_r0`=1 with `md_addr`=0: the sequencer passes both enables unchanged; the register file's low-word write to R0 takes effect.
- `halt_sys`=1:
  - output registers, FIFO, pointers and age counter hold;
  - `alu_valid` is ignored, and upstream holds the ALU result stable;
  - no push and no pop;
  - the register file clock-gates the held write, so it is not duplicated.
- `pending_mask` = OR over valid FIFO entries of (1<<`md_addr`) | (`md_r0`<<0), OR'd with the output stage's (1<<`write_address`)&{16{`write_en`}} and `R0_en`<<0.

## Timing
- Reset values: `write_en`=0, `R0_en`=0, `write_address`=0, `write_data`=0, `md_ready`=0, `wb_stall`=0, `pending_mask`=0. The FIFO is empty.
- Reset asserted mid-operation discards all buffered results immediately, without waiting for a clock edge.
- ALU latency: result presented in cycle N appears on `write_*` during N+1 and is written into the register file at the edge ending N+1.
- Mul/div latency, FIFO empty and no ALU traffic: accepted in N, popped in N+1, on `write_*` during N+2.
- `wb_stall` rises in the cycle after the age counter reaches AGE_MAX and falls in the cycle after the pop.
- Output enables are single-cycle pulses per result, except while held by `halt_sys`.

## Configuration
- `WB_PENDING_MASK_EN`
  - Defined: `pending_mask` is generated as described above.
  - Undefined: `pending_mask` is tied to 16'h0 and its logic is not built. All other behaviour is unchanged.

## Test plan
- Reset then ALU write: `alu_valid`=1, `alu_addr`=5, `alu_data`=16'h1234 in cycle N -> during N+1, `write_en`=1, `R0_en`=0, `write_address`=5, `write_data`=32'h0000_1234; during N+2, `write_en`=0.
- Mul/div with R0: `md_valid`=1, `md_addr`=3, `md_data`=32'hDEAD_BEEF, `md_r0`=1, no ALU -> two cycles later, `write_en`=1, `R0_en`=1, `write_data`=32'hDEAD_BEEF, `write_address`=3; `pending_mask`=16'h0009 while the entry is buffered.
- Priority and aging, AGE_MAX=4: one entry buffered with `alu_valid` held high -> `wb_stall`=1 after 4 blocked cycles; drop `alu_valid` -> entry written the next cycle, then `wb_stall`=0.
- FIFO full, FIFO_DEPTH=2: push 2 entries under continuous ALU traffic -> `md_ready`=0; a third `md_valid` is not accepted until after a pop.
- Halt: assert `halt_sys` for 3 cycles while `write_en`=1 and one entry is buffered -> outputs, `pending_mask` and `wb_stall` are frozen and `md_ready`=0; on release the entry drains in order.
- Reset mid-operation: assert `rst` with 2 entries buffered -> all outputs 0 immediately; no buffered write appears after reset is released.
